conv_col_sched: RTL

Sequencing controller for the `multi_mul` column multiplier array. It fetches weight columns and feature-map pixels from upstream FIFOs and drives the array's `i_enable_colw` and `i_enable_colip` strobes. It walks channels, kernel columns and pixels in a fixed loop order and emits a latency-matched tag stream (kernel column, pixel index, last) alongside the array's products. It sits between the weight/pixel FIFOs and the `multi_mul` + accumulator path.

---
 rtl/conv_sched_pkg.sv | 24 ++
 rtl/sched_tag_pipe.sv | 36 +++
 rtl/conv_col_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and defaults for the conv column scheduler.
package conv_sched_pkg;

  localparam int MUL_LAT_DEF = 2;
  localparam int PIX_W_DEF   = 8;
  localparam int KC_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CH_START = 3'd1,
    ST_FETCH_W  = 3'd2,
    ST_STREAM   = 3'd3,
    ST_COL_END  = 3'd4,
    ST_DONE     = 3'd5
  } sched_state_e;

  // One result tag as it travels beside the array products.
  typedef struct packed {
    logic [KC_W-1:0]      kercol;
    logic [PIX_W_DEF-1:0] pix;
    logic                 last;
  } sched_tag_t;

endpackage

// File: rtl/sched_tag_pipe.sv
// Fixed-latency valid+tag delay line matching the multiplier array latency.
// Tags are zeroed when invalid so the result tag outputs read 0 between results.
module sched_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag
);

  logic [DEPTH-1:0] r_vld;
  logic [TAG_W-1:0] r_tag [DEPTH];

  // Shift every cycle regardless of downstream stall; reset flushes all stages.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_tag[0] <= i_valid ? i_tag : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign o_valid = r_vld[DEPTH-1];
  assign o_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/conv_col_sched.sv
// Column scheduler for the multi_mul array: walks channel -> kernel column ->
// pixel, drives the array enables and emits a latency-matched result tag stream.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for i_start
// CH_START   | one-cycle colip pulse, kernel column reset to 0
// FETCH_W    | waiting for a weight column; colw fires on the handshake
// STREAM     | issuing pixels of the current column to the array
// COL_END    | draining the array for MUL_LAT cycles, then advance loops
// DONE       | one-cycle o_done pulse
module conv_col_sched
  import conv_sched_pkg::*;
#(
  parameter int BIT_WIDTH     = 8,
  parameter int NO_COL_KERNEL = 5,
  parameter int PIX_W         = PIX_W_DEF,
  parameter int CH_W          = 6,
  parameter int MUL_LAT       = MUL_LAT_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [PIX_W-1:0] i_cfg_npix,
  input  logic [CH_W-1:0]  i_cfg_nch,
  input  logic             i_w_valid,
  output logic             o_w_ready,
  input  logic             i_px_valid,
  output logic             o_px_ready,
  input  logic             i_stall,
  output logic             o_enable_colw,
  output logic             o_enable_colip,
  output logic             o_mul_fire,
  output logic [2:0]       o_kercol_id,
  output logic [PIX_W-1:0] o_pix_idx,
  output logic [CH_W-1:0]  o_ch_idx,
  output logic             o_res_valid,
  output logic [2:0]       o_res_kercol,
  output logic [PIX_W-1:0] o_res_pix,
  output logic             o_res_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam int DW    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int TAG_W = KC_W + PIX_W + 1;

  if (NO_COL_KERNEL < 1 || NO_COL_KERNEL > 7 || MUL_LAT < 1 || BIT_WIDTH < 1) begin : g_bad_cfg
    $error("conv_col_sched: unsupported parameter set");
  end

  sched_state_e     r_state, w_state_nxt;
  logic [PIX_W-1:0] r_npix, r_pix;
  logic [CH_W-1:0]  r_nch, r_ch;
  logic [2:0]       r_kercol;
  logic [DW-1:0]    r_drain;

  logic             w_pix_last, w_kc_last, w_ch_last, w_tag_last;
  logic [TAG_W-1:0] w_tag_in, w_res_tag;

  assign w_pix_last = (r_pix == r_npix - PIX_W'(1));
  assign w_kc_last  = (r_kercol == 3'(NO_COL_KERNEL - 1));
  assign w_ch_last  = (r_ch == r_nch - CH_W'(1));
  assign w_tag_last = w_pix_last && w_kc_last && w_ch_last;
  assign w_tag_in   = {r_kercol, r_pix, w_tag_last};

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and Moore/handshake outputs; enables have no registered lag.
  always_comb begin
    w_state_nxt    = r_state;
    o_enable_colip = 1'b0;
    o_enable_colw  = 1'b0;
    o_w_ready      = 1'b0;
    o_px_ready     = 1'b0;
    o_mul_fire     = 1'b0;
    o_done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_cfg_npix != '0 && i_cfg_nch != '0) ? ST_CH_START : ST_DONE;
        end
      end
      ST_CH_START: begin
        o_enable_colip = 1'b1;
        w_state_nxt    = ST_FETCH_W;
      end
      ST_FETCH_W: begin
        o_w_ready = 1'b1;
        if (i_w_valid) begin
          o_enable_colw = 1'b1;
          w_state_nxt   = ST_STREAM;
        end
      end
      ST_STREAM: begin
        o_px_ready = !i_stall;
        if (i_px_valid && !i_stall) begin
          o_mul_fire = 1'b1;
          if (w_pix_last) w_state_nxt = ST_COL_END;
        end
      end
      ST_COL_END: begin
        if (r_drain == '0) begin
          if (!w_kc_last)      w_state_nxt = ST_FETCH_W;
          else if (!w_ch_last) w_state_nxt = ST_CH_START;
          else                 w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Loop counters, latched config and the column drain down-counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_npix   <= '0;
      r_nch    <= '0;
      r_pix    <= '0;
      r_ch     <= '0;
      r_kercol <= '0;
      r_drain  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_npix   <= i_cfg_npix;
            r_nch    <= i_cfg_nch;
            r_pix    <= '0;
            r_ch     <= '0;
            r_kercol <= '0;
          end
        end
        ST_CH_START: r_kercol <= '0;
        ST_FETCH_W: begin
          if (i_w_valid) r_pix <= '0;
        end
        ST_STREAM: begin
          if (o_mul_fire) begin
            r_pix <= r_pix + PIX_W'(1);
            if (w_pix_last) r_drain <= DW'(MUL_LAT - 1);
          end
        end
        ST_COL_END: begin
          if (r_drain != '0)   r_drain  <= r_drain - DW'(1);
          else if (!w_kc_last) r_kercol <= r_kercol + 3'd1;
          else if (!w_ch_last) r_ch     <= r_ch + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_kercol_id = r_kercol;
  assign o_pix_idx   = r_pix;
  assign o_ch_idx    = r_ch;

  sched_tag_pipe #(
    .DEPTH (MUL_LAT),
    .TAG_W (TAG_W)
  ) u_tag_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (o_mul_fire),
    .i_tag   (w_tag_in),
    .o_valid (o_res_valid),
    .o_tag   (w_res_tag)
  );

  assign {o_res_kercol, o_res_pix, o_res_last} = w_res_tag;

endmodule
